// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with a bounded hold time.
// A grant lasts until its requester releases or it has been held MAX_HOLD cycles.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic [7:0]  hold_cnt
);

  localparam logic [7:0] LAST_HOLD = 8'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [3:0]  idx_n;
  logic [3:0]  next_ptr;
  logic [7:0]  hold_n;
  logic [4:0]  pick;

  // Returns {found, index} of the first set bit at or after start, wrapping 15->0.
  // Scanning from the far end lets the nearest match overwrite earlier ones.
  function automatic logic [4:0] rr_pick(input logic [15:0] mask, input logic [3:0] start);
    logic [4:0] r;
    logic [3:0] k;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      k = start + 4'(i);
      if (mask[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  assign next_ptr = gnt_idx + 4'd1;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    hold_n  = hold_cnt;
    pick    = '0;
    case (state)
      IDLE: begin
        pick   = rr_pick(req, ptr);
        idx_n  = pick[3:0];
        hold_n = '0;
        if (pick[4]) state_n = GRANT;
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          // Release: the departing bit is excluded so the next owner is chosen this edge.
          ptr_n  = next_ptr;
          pick   = rr_pick(req & ~(16'h0001 << gnt_idx), next_ptr);
          idx_n  = pick[3:0];
          hold_n = '0;
          if (!pick[4]) state_n = IDLE;
        end else if (hold_cnt == LAST_HOLD) begin
          // Preemption: the holder sits last in the new order, so it wins only if alone.
          ptr_n  = next_ptr;
          pick   = rr_pick(req, next_ptr);
          idx_n  = pick[3:0];
          hold_n = '0;
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt_idx   <= idx_n;
      hold_cnt  <= hold_n;
      gnt_valid <= (state_n == GRANT);
      gnt       <= (state_n == GRANT) ? (16'h0001 << idx_n) : 16'h0000;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus random traffic,
// compared every cycle against a behavioural owner/pointer/hold model.
module tb_rr_arbiter_16;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic [7:0]  hold_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: owner is -1 when nobody holds the grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_arbiter_16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int first_from(input logic [15:0] mask, input int start);
    for (int off = 0; off < 16; off++) begin
      if (mask[(start + off) % 16]) return (start + off) % 16;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [15:0] q);
    logic [15:0] others;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      m_owner = first_from(q, m_ptr);
      m_hold  = 0;
    end else if (!q[m_owner]) begin
      m_ptr   = (m_owner + 1) % 16;
      others  = q;
      others[m_owner] = 1'b0;
      m_owner = first_from(others, m_ptr);
      m_hold  = 0;
    end else if (m_hold == MAX_HOLD - 1) begin
      m_ptr   = (m_owner + 1) % 16;
      m_owner = first_from(q, m_ptr);
      m_hold  = 0;
    end else begin
      m_hold++;
    end
  endtask

  // Drive inputs mid-cycle, advance one edge, then compare all outputs to the model.
  task automatic step(input logic r, input logic [15:0] q);
    logic [15:0] exp_gnt;
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    model_edge(r, q);
    #1;
    exp_gnt = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
    check("gnt",       32'(gnt),       32'(exp_gnt));
    check("gnt_idx",   32'(gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("hold_cnt",  32'(hold_cnt),  32'(m_hold));
  endtask

  initial begin
    int          exp_seq;
    int          prev_owner;
    logic [15:0] rq;

    // Reset, then an idle stretch with no requests.
    step(1'b1, 16'h0000);
    step(1'b1, 16'hFFFF);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000);

    // One-cycle latency and gapless handover on release.
    step(1'b0, 16'h0050);
    check("first_grant_onehot", 32'(gnt), 32'h0010);
    check("first_grant_idx",    32'(gnt_idx), 32'd4);
    step(1'b0, 16'h0040);
    check("handover_onehot", 32'(gnt), 32'h0040);
    check("handover_idx",    32'(gnt_idx), 32'd6);

    // Two persistent requesters alternate every MAX_HOLD cycles.
    step(1'b1, 16'h0000);
    for (int i = 0; i < 48; i++) step(1'b0, 16'h8001);

    // Sole requester is re-granted after the hold limit with HOLD_CNT back at 0.
    step(1'b1, 16'h0000);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0008);
    check("sole_regrant_gnt", 32'(gnt), 32'h0008);
    check("sole_regrant_hold", 32'(hold_cnt), 32'd1);

    // Pointer wrap past 15, then all requesters served in strict order.
    step(1'b1, 16'h0000);
    step(1'b0, 16'h8000);
    step(1'b0, 16'h8002);
    step(1'b0, 16'h0002);
    check("wrap_idx", 32'(gnt_idx), 32'd1);
    exp_seq    = 2;
    prev_owner = m_owner;
    for (int i = 0; i < 16 * MAX_HOLD; i++) begin
      step(1'b0, 16'hFFFF);
      if (m_owner != prev_owner) begin
        check("rr_order", 32'(gnt_idx), 32'(exp_seq));
        exp_seq    = (exp_seq + 1) % 16;
        prev_owner = m_owner;
      end
    end

    // Reset in the middle of a grant drops it and restarts the pointer at 0.
    step(1'b1, 16'h0000);
    step(1'b0, 16'h0200);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0200);
    check("pre_reset_idx",  32'(gnt_idx), 32'd9);
    check("pre_reset_hold", 32'(hold_cnt), 32'd3);
    step(1'b1, 16'h0200);
    check("reset_drops_gnt", 32'(gnt), 32'h0000);
    step(1'b0, 16'h0201);
    check("post_reset_idx", 32'(gnt_idx), 32'd0);

    // Random traffic: requests change occasionally so holds and preemptions occur.
    rq = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: rq = 16'($urandom);
          1: rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2: rq = rq ^ (16'h0001 << $urandom_range(15));
          default: rq = 16'h0000;
        endcase
      end
      step($urandom_range(99) == 0, rq);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
